serv_pc_seq: RTL and testbench

- Bit-serial sequencer that drives the PC/control datapath (serv_ctrl) through fetch and execute.
- Issues the instruction fetch handshake and generates the 32-cycle serial count with its strobes (cnt0, cnt1, cnt2, cnt12to31) and the PC shift enable.
- Inserts a trap pass when a trap is requested or when a jump target is misaligned.
- Sits between the decoder/ibus and serv_ctrl; owns no datapath bits itself.

---
 rtl/serv_pkg.sv | 16 +
 rtl/serv_bitcnt.sv | 34 +++
 rtl/serv_pc_seq.sv | 118 +++++++++++
 tb/tb_serv_pc_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/serv_pkg.sv
// Shared types and constants for the bit-serial core.
// State encoding used by the PC sequencer and its helpers.
package serv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    RUN,
    TRAP
  } state_t;

endpackage

// File: rtl/serv_bitcnt.sv
// Serial bit counter with strobe decode.
// Wraps after 32 enabled cycles so each pass ends back at zero.
module serv_bitcnt
  import serv_pkg::*;
(
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_cnt0,
  output logic             o_cnt1,
  output logic             o_cnt2,
  output logic             o_cnt12to31,
  output logic             o_last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign o_cnt       = cnt;
  assign o_cnt0      = (cnt == CNT_W'(0));
  assign o_cnt1      = (cnt == CNT_W'(1));
  assign o_cnt2      = (cnt == CNT_W'(2));
  assign o_cnt12to31 = (cnt >= CNT_W'(12));
  assign o_last      = &cnt;

endmodule

// File: rtl/serv_pc_seq.sv
// Fetch/execute sequencer for the serial PC datapath.
// Runs 32-cycle RUN and TRAP passes and raises the fetch handshake.
module serv_pc_seq
  import serv_pkg::*;
#(
  parameter bit COMPRESSED    = 1'b0,
  parameter int FETCH_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_ibus_ack,
  input  logic             i_jump,
  input  logic             i_trap_req,
  input  logic             i_bad_pc,
  output logic             o_ibus_cyc,
  output logic             o_pc_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_cnt0,
  output logic             o_cnt1,
  output logic             o_cnt2,
  output logic             o_cnt12to31,
  output logic             o_jump,
  output logic             o_trap,
  output logic             o_misalign,
  output logic             o_fetch_err
);

  localparam logic [15:0] TMO_LAST =
    16'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);

  state_t state, state_nx;

  logic             jump_r;
  logic             trap_r;
  logic             mis_r;
  logic             err_r;
  logic [15:0]      tmo;
  logic             active;
  logic             mis_hit;
  logic             tmo_hit;
  logic [CNT_W-1:0] cnt;
  logic             c0, c1, c2, c12, last;

  assign active = (state == RUN) || (state == TRAP);

  serv_bitcnt u_bitcnt (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_en        (active),
    .o_cnt       (cnt),
    .o_cnt0      (c0),
    .o_cnt1      (c1),
    .o_cnt2      (c2),
    .o_cnt12to31 (c12),
    .o_last      (last)
  );

  // With C enabled, 2-byte aligned targets are legal.
  assign mis_hit = (state == RUN) && c1 && !COMPRESSED
                && jump_r && i_bad_pc;

  // tmo counts completed FETCH cycles, so TMO_LAST marks the Nth one.
  assign tmo_hit = (FETCH_TIMEOUT > 0) && (state == FETCH)
                && (tmo == TMO_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = FETCH;
      FETCH:   if (i_ibus_ack) state_nx = DECODE;
      DECODE:  state_nx = i_trap_req ? TRAP : RUN;
      RUN:     if (last) state_nx = mis_r ? TRAP : FETCH;
      TRAP:    if (last) state_nx = FETCH;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      jump_r <= 1'b0;
      trap_r <= 1'b0;
      mis_r  <= 1'b0;
      err_r  <= 1'b0;
      tmo    <= '0;
    end else begin
      state <= state_nx;
      if (state == DECODE) begin
        jump_r <= i_jump;
        trap_r <= i_trap_req;
      end
      if (mis_hit) mis_r <= 1'b1;
      if ((state == TRAP) && last) begin
        mis_r  <= 1'b0;
        trap_r <= 1'b0;
      end
      if (tmo_hit) err_r <= 1'b1;
      if (state != FETCH || i_ibus_ack) begin
        tmo <= '0;
      end else if (tmo != 16'hFFFF) begin
        tmo <= tmo + 16'd1;
      end
    end
  end

  assign o_ibus_cyc  = (state == FETCH);
  assign o_pc_en     = active;
  assign o_cnt       = active ? cnt : '0;
  assign o_cnt0      = active && c0;
  assign o_cnt1      = active && c1;
  assign o_cnt2      = active && c2;
  assign o_cnt12to31 = active && c12;
  assign o_jump      = (state == RUN) && jump_r;
  assign o_trap      = (state == TRAP) && (trap_r || mis_r);
  assign o_misalign  = mis_hit;
  assign o_fetch_err = err_r || tmo_hit;

endmodule

// File: tb/tb_serv_pc_seq.sv
// Directed bench for serv_pc_seq: two instances (C off with timeout 4,
// C on without timeout) share stimulus; per-instruction counts are checked.
module tb_serv_pc_seq;

  typedef struct {
    bit jump;
    bit trap;
    bit bad;
    int wait_n;
    bit hold;
    int r0, t0, m0, e0;
    int r1, t1, m1, e1;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       ack;
  logic       jump;
  logic       trap_req;
  logic       bad_pc;
  logic [1:0] cyc, pe, c0, c1, c2, c12, jmp, trp, mis, err;
  logic [4:0] cnt [2];

  int ntests = 0;
  int nfail  = 0;

  int f_n [2], gap_n [2], pe_n [2], run_n [2], trap_n [2];
  int mis_n [2], c12_n [2], jmp_n [2], err_at [2], serr [2];
  bit seen_cyc [2], seen_pe [2], done [2], err_end [2];

  vec_t vt [7];

  serv_pc_seq #(.COMPRESSED(1'b0), .FETCH_TIMEOUT(4)) u_dut0 (
    .clk(clk), .i_rst_n(rst_n), .i_ibus_ack(ack), .i_jump(jump),
    .i_trap_req(trap_req), .i_bad_pc(bad_pc),
    .o_ibus_cyc(cyc[0]), .o_pc_en(pe[0]), .o_cnt(cnt[0]),
    .o_cnt0(c0[0]), .o_cnt1(c1[0]), .o_cnt2(c2[0]),
    .o_cnt12to31(c12[0]), .o_jump(jmp[0]), .o_trap(trp[0]),
    .o_misalign(mis[0]), .o_fetch_err(err[0])
  );

  serv_pc_seq #(.COMPRESSED(1'b1), .FETCH_TIMEOUT(0)) u_dut1 (
    .clk(clk), .i_rst_n(rst_n), .i_ibus_ack(ack), .i_jump(jump),
    .i_trap_req(trap_req), .i_bad_pc(bad_pc),
    .o_ibus_cyc(cyc[1]), .o_pc_en(pe[1]), .o_cnt(cnt[1]),
    .o_cnt0(c0[1]), .o_cnt1(c1[1]), .o_cnt2(c2[1]),
    .o_cnt12to31(c12[1]), .o_jump(jmp[1]), .o_trap(trp[1]),
    .o_misalign(mis[1]), .o_fetch_err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr_stats();
    for (int d = 0; d < 2; d++) begin
      f_n[d] = 0; gap_n[d] = 0; pe_n[d] = 0; run_n[d] = 0;
      trap_n[d] = 0; mis_n[d] = 0; c12_n[d] = 0; jmp_n[d] = 0;
      err_at[d] = 0; serr[d] = 0; seen_cyc[d] = 0; seen_pe[d] = 0;
      done[d] = 0; err_end[d] = 0;
    end
  endtask

  // Reset both instances; release just after a rising edge so the
  // following falling edge still sees IDLE.
  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    ack   = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk({nm, ".idle"}, int'(cyc), 0);
  endtask

  task automatic sample(input int d);
    int k;
    if (done[d]) return;
    if (cyc[d]) begin
      if (seen_pe[d]) begin
        done[d]    = 1;
        err_end[d] = err[d];
        return;
      end
      f_n[d]++;
      seen_cyc[d] = 1;
      if (err[d] && err_at[d] == 0) err_at[d] = f_n[d];
      if (pe[d]) serr[d]++;
    end else if (!pe[d] && seen_cyc[d] && !seen_pe[d]) begin
      gap_n[d]++;
    end
    if (pe[d]) begin
      k = pe_n[d] % 32;
      seen_pe[d] = 1;
      if (int'(cnt[d]) != k) serr[d]++;
      if (c0[d] != (k == 0)) serr[d]++;
      if (c1[d] != (k == 1)) serr[d]++;
      if (c2[d] != (k == 2)) serr[d]++;
      if (c12[d] != (k >= 12)) serr[d]++;
      if (mis[d] && k != 1) serr[d]++;
      if (trp[d] && jmp[d]) serr[d]++;
      pe_n[d]++;
      if (trp[d]) trap_n[d]++; else run_n[d]++;
      if (mis[d]) mis_n[d]++;
      if (c12[d]) c12_n[d]++;
      if (jmp[d]) jmp_n[d]++;
    end else begin
      if (cnt[d] != 0 || c0[d] || c1[d] || c2[d] || c12[d]) serr[d]++;
      if (jmp[d] || trp[d] || mis[d]) serr[d]++;
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string nm;
    int    er, et, em, ee, ej;
    jump     = v.jump;
    trap_req = v.trap;
    bad_pc   = v.bad;
    clr_stats();
    do_reset($sformatf("v%0d", i));
    for (int n = 0; n < 150 && !(done[0] && done[1]); n++) begin
      @(negedge clk);
      sample(0);
      sample(1);
      if (cyc[0] && !seen_pe[0]) begin
        if (f_n[0] >= v.wait_n) ack = 1'b1;
      end else if (!v.hold) begin
        ack = 1'b0;
      end
    end
    ack = 1'b0;
    for (int d = 0; d < 2; d++) begin
      nm = $sformatf("v%0d.d%0d", i, d);
      er = d ? v.r1 : v.r0;
      et = d ? v.t1 : v.t0;
      em = d ? v.m1 : v.m0;
      ee = d ? v.e1 : v.e0;
      ej = (v.jump && !v.trap) ? er : 0;
      chk({nm, ".done"},   int'(done[d]), 1);
      chk({nm, ".fetch"},  f_n[d], v.wait_n);
      chk({nm, ".decode"}, gap_n[d], 1);
      chk({nm, ".run"},    run_n[d], er);
      chk({nm, ".trap"},   trap_n[d], et);
      chk({nm, ".mis"},    mis_n[d], em);
      chk({nm, ".c12"},    c12_n[d], ((er + et) / 32) * 20);
      chk({nm, ".jump"},   jmp_n[d], ej);
      chk({nm, ".errat"},  err_at[d], ee);
      chk({nm, ".errend"}, int'(err_end[d]), int'(ee != 0));
      chk({nm, ".seq"},    serr[d], 0);
    end
  endtask

  initial begin
    bit found;
    rst_n    = 1'b0;
    ack      = 1'b0;
    jump     = 1'b0;
    trap_req = 1'b0;
    bad_pc   = 1'b0;

    //        jmp trp bad wt hold  r0 t0 m0 e0   r1 t1 m1 e1
    vt[0] = '{0, 0, 0, 3, 0,   32, 0, 0, 0,  32, 0, 0, 0};
    vt[1] = '{1, 0, 1, 1, 0,   32, 32, 1, 0, 32, 0, 0, 0};
    vt[2] = '{1, 1, 1, 2, 0,   0, 32, 0, 0,  0, 32, 0, 0};
    vt[3] = '{1, 0, 0, 1, 0,   32, 0, 0, 0,  32, 0, 0, 0};
    vt[4] = '{0, 0, 0, 10, 0,  32, 0, 0, 4,  32, 0, 0, 0};
    vt[5] = '{0, 0, 1, 2, 0,   32, 0, 0, 0,  32, 0, 0, 0};
    vt[6] = '{0, 0, 0, 1, 1,   32, 0, 0, 0,  32, 0, 0, 0};

    #1;
    chk("reset.outs", int'({cyc, pe, c0, c1, c2, c12, jmp, trp, mis, err}), 0);
    chk("reset.cnt", int'(cnt[0]) + int'(cnt[1]), 0);

    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

    // Reset in the middle of a RUN pass.
    jump     = 1'b0;
    trap_req = 1'b0;
    bad_pc   = 1'b0;
    do_reset("mid");
    found = 0;
    for (int n = 0; n < 80 && !found; n++) begin
      @(negedge clk);
      if (cyc[0]) ack = 1'b1; else ack = 1'b0;
      if (pe[0] && cnt[0] == 5'd17) found = 1;
    end
    ack = 1'b0;
    chk("mid.reach17", int'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("mid.async.pe", int'(pe), 0);
    chk("mid.async.cnt", int'(cnt[0]) + int'(cnt[1]), 0);
    chk("mid.async.strb", int'({c0, c1, c2, c12, jmp, trp, mis}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid.idle", int'(cyc), 0);
    @(negedge clk);
    chk("mid.fetch", int'(cyc), 3);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
